drv_led_w: RTL and testbench

DRV_LED_W -- requirements
Module: drv_led_w

---
 rtl/drv_led_w.sv | 102 ++++++++++
 tb/tb_drv_led_w.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drv_led_w.sv
// Row of LED drivers with steady, shared-phase blink and one-shot flash per channel.
// A common prescaler paces both the blink phase and the flash countdown.
module drv_led_w #(
  parameter int    p_width = 4,
  parameter int    p_scale = 5,
  parameter string p_mode  = "pullup",
  parameter int    p_flash = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_width-1:0] i_on,
  input  logic [p_width-1:0] i_blink,
  input  logic [p_width-1:0] i_flash,
  output logic [p_width-1:0] o_drv_led,
  output logic [p_width-1:0] o_state,
  output logic               o_busy
);

  localparam int cnt_w = $clog2(p_flash + 1);
  localparam logic [cnt_w-1:0] flash_load = cnt_w'(p_flash);
  localparam bit active_low = (p_mode == "pullup");

  generate
    if (!(p_mode == "pullup" || p_mode == "pulldown")) begin : g_bad_mode
      $error("drv_led_w: p_mode must be pullup or pulldown");
    end
    if (p_scale < 1 || p_scale > 24) begin : g_bad_scale
      $error("drv_led_w: p_scale must be in 1..24");
    end
    if (p_flash < 1 || p_flash > 255) begin : g_bad_flash
      $error("drv_led_w: p_flash must be in 1..255");
    end
    if (p_width < 1) begin : g_bad_width
      $error("drv_led_w: p_width must be at least 1");
    end
  endgenerate

  logic [p_scale-1:0] presc_reg;
  logic               phase_reg;
  logic               tick;
  logic [p_width-1:0] flash_act;
  logic [p_width-1:0] state_next;
  logic [p_width-1:0] state_reg;
  logic               busy_reg;

  assign tick = &presc_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_reg <= '0;
      phase_reg <= 1'b0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
      phase_reg <= phase_reg ^ tick;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < p_width; gi++) begin : g_ch
      logic [cnt_w-1:0] cnt_reg;
      logic [cnt_w-1:0] cnt_next;

      // A trigger always reloads, even on a tick, so the full duration restarts.
      always_comb begin
        cnt_next = cnt_reg;
        if (i_flash[gi]) begin
          cnt_next = flash_load;
        end else if (tick && flash_act[gi]) begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign flash_act[gi]  = (cnt_reg != '0);
      assign state_next[gi] = flash_act[gi] ? 1'b1
                            : (i_blink[gi] ? phase_reg : i_on[gi]);
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= |flash_act;
    end
  end

  assign o_state   = state_reg;
  assign o_busy    = busy_reg;
  assign o_drv_led = active_low ? ~state_reg : state_reg;

endmodule

// File: tb/tb_drv_led_w.sv
// Scoreboard bench for drv_led_w: expected {state,busy} pushed at stimulus time,
// popped and compared each cycle; a pulldown twin shares the stimulus.
module tb_drv_led_w;

  logic       i_clk;
  logic       i_rst;
  logic [3:0] i_on;
  logic [3:0] i_blink;
  logic [3:0] i_flash;
  logic [3:0] o_drv_led;
  logic [3:0] o_state;
  logic       o_busy;
  logic [3:0] o_drv_led_pd;
  logic [3:0] o_state_pd;
  logic       o_busy_pd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [4:0] sb[$];

  drv_led_w #(.p_width(4), .p_scale(2), .p_mode("pullup"), .p_flash(3)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_on(i_on), .i_blink(i_blink), .i_flash(i_flash),
    .o_drv_led(o_drv_led), .o_state(o_state), .o_busy(o_busy)
  );

  drv_led_w #(.p_width(4), .p_scale(2), .p_mode("pulldown"), .p_flash(3)) u_dut_pd (
    .i_clk(i_clk), .i_rst(i_rst), .i_on(i_on), .i_blink(i_blink), .i_flash(i_flash),
    .o_drv_led(o_drv_led_pd), .o_state(o_state_pd), .o_busy(o_busy_pd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Clocks since reset release; the prescaler value is cyc mod 4.
  always @(posedge i_clk) begin
    if (i_rst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic align(input int ph);
    int guard;
    guard = 0;
    while ((cyc % 4) != ph && guard < 8) begin
      @(negedge i_clk);
      guard++;
    end
    if ((cyc % 4) != ph) begin
      n_fail++;
      $display("FAIL align: cyc=%0d required phase %0d", cyc, ph);
    end
  endtask

  task automatic test_reset();
    logic [4:0] e;
    logic b;
    i_rst = 1'b1; i_on = 4'b0000; i_blink = 4'b0001; i_flash = 4'b0000;
    for (int k = 1; k <= 2; k++) sb.push_back(5'b0000_0);
    for (int k = 1; k <= 8; k++) begin
      b = (((k - 1) / 4) % 2) == 1;
      sb.push_back({3'b000, b, 1'b0});
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      e = sb.pop_front();
      n_checks++;
      if ({o_state, o_busy, o_drv_led, o_drv_led_pd} !== {e, ~e[4:1], e[4:1]}) begin
        n_fail++;
        $display("FAIL reset k=%0d got state=%b busy=%b led=%b led_pd=%b required state=%b busy=%b",
                 k, o_state, o_busy, o_drv_led, o_drv_led_pd, e[4:1], e[0]);
      end else $display("reset k=%0d state=%b busy=%b led=%b", k, o_state, o_busy, o_drv_led);
      if (k == 2) i_rst = 1'b0;
    end
    i_blink = 4'b0000;
  endtask

  task automatic test_steady();
    logic [4:0] e;
    i_on = 4'b0101; i_blink = 4'b0000; i_flash = 4'b0000;
    sb.push_back(5'b0101_0); sb.push_back(5'b0101_0);
    sb.push_back(5'b1010_0); sb.push_back(5'b1010_0);
    sb.push_back(5'b0000_0); sb.push_back(5'b0000_0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge i_clk);
      e = sb.pop_front();
      n_checks++;
      if ({o_state, o_busy, o_drv_led, o_drv_led_pd} !== {e, ~e[4:1], e[4:1]}) begin
        n_fail++;
        $display("FAIL steady k=%0d got state=%b busy=%b led=%b led_pd=%b required state=%b busy=%b",
                 k, o_state, o_busy, o_drv_led, o_drv_led_pd, e[4:1], e[0]);
      end else $display("steady k=%0d state=%b led=%b led_pd=%b", k, o_state, o_drv_led, o_drv_led_pd);
      if (k == 2) i_on = 4'b1010;
      if (k == 4) i_on = 4'b0000;
    end
  endtask

  task automatic test_blink();
    logic [4:0] e;
    logic b;
    int c0;
    c0 = cyc;
    i_on = 4'b0010; i_blink = 4'b0011; i_flash = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      b = (((c0 + k - 1) / 4) % 2) == 1;
      sb.push_back({2'b00, b, b, 1'b0});
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge i_clk);
      e = sb.pop_front();
      n_checks++;
      if ({o_state, o_busy, o_drv_led, o_drv_led_pd} !== {e, ~e[4:1], e[4:1]}) begin
        n_fail++;
        $display("FAIL blink k=%0d got state=%b busy=%b led=%b required state=%b busy=%b",
                 k, o_state, o_busy, o_drv_led, e[4:1], e[0]);
      end else $display("blink k=%0d state=%b", k, o_state);
    end
    i_on = 4'b0000; i_blink = 4'b0000;
  endtask

  task automatic test_flash();
    logic [4:0] e;
    align(0);
    i_on = 4'b0000; i_blink = 4'b0000; i_flash = 4'b0100;
    for (int k = 1; k <= 14; k++) sb.push_back((k >= 2 && k <= 12) ? 5'b0100_1 : 5'b0000_0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge i_clk);
      if (k == 1) i_flash = 4'b0000;
      e = sb.pop_front();
      n_checks++;
      if ({o_state, o_busy, o_drv_led, o_drv_led_pd} !== {e, ~e[4:1], e[4:1]}) begin
        n_fail++;
        $display("FAIL flash k=%0d got state=%b busy=%b led=%b required state=%b busy=%b",
                 k, o_state, o_busy, o_drv_led, e[4:1], e[0]);
      end else $display("flash k=%0d state=%b busy=%b", k, o_state, o_busy);
    end
  endtask

  task automatic test_retrigger();
    logic [4:0] e;
    align(0);
    i_on = 4'b0000; i_blink = 4'b0000; i_flash = 4'b0100;
    for (int k = 1; k <= 18; k++) sb.push_back((k >= 2 && k <= 16) ? 5'b0100_1 : 5'b0000_0);
    for (int k = 1; k <= 18; k++) begin
      @(negedge i_clk);
      if (k == 1 || k == 7) i_flash = 4'b0000;
      if (k == 6) i_flash = 4'b0100;
      e = sb.pop_front();
      n_checks++;
      if ({o_state, o_busy, o_drv_led, o_drv_led_pd} !== {e, ~e[4:1], e[4:1]}) begin
        n_fail++;
        $display("FAIL retrigger k=%0d got state=%b busy=%b required state=%b busy=%b",
                 k, o_state, o_busy, e[4:1], e[0]);
      end else $display("retrigger k=%0d state=%b busy=%b", k, o_state, o_busy);
    end
  endtask

  task automatic test_flash_on_tick();
    logic [4:0] e;
    align(3);
    i_on = 4'b0000; i_blink = 4'b0000; i_flash = 4'b0100;
    for (int k = 1; k <= 15; k++) sb.push_back((k >= 2 && k <= 13) ? 5'b0100_1 : 5'b0000_0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge i_clk);
      if (k == 1) i_flash = 4'b0000;
      e = sb.pop_front();
      n_checks++;
      if ({o_state, o_busy, o_drv_led, o_drv_led_pd} !== {e, ~e[4:1], e[4:1]}) begin
        n_fail++;
        $display("FAIL flash_on_tick k=%0d got state=%b busy=%b required state=%b busy=%b",
                 k, o_state, o_busy, e[4:1], e[0]);
      end else $display("flash_on_tick k=%0d state=%b busy=%b", k, o_state, o_busy);
    end
  endtask

  task automatic test_flash_blink();
    logic [4:0] e;
    logic b;
    int c0;
    align(0);
    c0 = cyc;
    i_on = 4'b0000; i_blink = 4'b0100; i_flash = 4'b0100;
    for (int k = 1; k <= 20; k++) begin
      b = (((c0 + k - 1) / 4) % 2) == 1;
      if (k >= 2 && k <= 12) sb.push_back(5'b0100_1);
      else                   sb.push_back({1'b0, b, 2'b00, 1'b0});
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (k == 1) i_flash = 4'b0000;
      e = sb.pop_front();
      n_checks++;
      if ({o_state, o_busy, o_drv_led, o_drv_led_pd} !== {e, ~e[4:1], e[4:1]}) begin
        n_fail++;
        $display("FAIL flash_blink k=%0d got state=%b busy=%b required state=%b busy=%b",
                 k, o_state, o_busy, e[4:1], e[0]);
      end else $display("flash_blink k=%0d state=%b busy=%b", k, o_state, o_busy);
    end
    i_blink = 4'b0000;
  endtask

  task automatic test_multi();
    logic [4:0] e;
    align(0);
    i_on = 4'b0100; i_blink = 4'b0000; i_flash = 4'b1011;
    for (int k = 1; k <= 14; k++) sb.push_back((k >= 2 && k <= 12) ? 5'b1111_1 : 5'b0100_0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge i_clk);
      if (k == 1) i_flash = 4'b0000;
      e = sb.pop_front();
      n_checks++;
      if ({o_state, o_busy, o_drv_led, o_drv_led_pd} !== {e, ~e[4:1], e[4:1]}) begin
        n_fail++;
        $display("FAIL multi k=%0d got state=%b busy=%b required state=%b busy=%b",
                 k, o_state, o_busy, e[4:1], e[0]);
      end else $display("multi k=%0d state=%b busy=%b", k, o_state, o_busy);
    end
    i_on = 4'b0000;
  endtask

  task automatic test_reset_mid_flash();
    logic [4:0] e;
    align(0);
    i_on = 4'b0000; i_blink = 4'b0000; i_flash = 4'b0100;
    for (int k = 1; k <= 12; k++) sb.push_back((k >= 2 && k <= 5) ? 5'b0100_1 : 5'b0000_0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge i_clk);
      if (k == 1) i_flash = 4'b0000;
      if (k == 5) begin i_rst = 1'b1; i_flash = 4'b0010; end
      if (k == 6) begin i_rst = 1'b0; i_flash = 4'b0000; end
      e = sb.pop_front();
      n_checks++;
      if ({o_state, o_busy, o_drv_led, o_drv_led_pd} !== {e, ~e[4:1], e[4:1]}) begin
        n_fail++;
        $display("FAIL reset_mid_flash k=%0d got state=%b busy=%b led=%b required state=%b busy=%b",
                 k, o_state, o_busy, o_drv_led, e[4:1], e[0]);
      end else $display("reset_mid_flash k=%0d state=%b busy=%b led=%b", k, o_state, o_busy, o_drv_led);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_on = 4'b0000; i_blink = 4'b0000; i_flash = 4'b0000;
    test_reset();
    test_steady();
    test_blink();
    test_flash();
    test_retrigger();
    test_flash_on_tick();
    test_flash_blink();
    test_multi();
    test_reset_mid_flash();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
